qam_demapper_multi: RTL and testbench
=====================================

Name: qam_demapper_multi

Overview:
- Parametrised multi-mode hard-decision QAM demapper. Supports QPSK, 16-QAM and 64-QAM.
- Takes signed fixed-point I/Q symbols over a valid/ready handshake and scales each by a per-mode normalisation constant.
- Slices each axis into Gray-coded bits and packs NSYM symbols into one frame word.
- Double-buffered: assembly register plus output register, so a new frame can fill while the previous one awaits out_ready.

Parameters:
- WIDTH, 16: I/Q sample width, signed two's complement, FRAC fractional bits.
- FRAC, 8: fractional bits of samples and constants. Constraint: FRAC <= WIDTH-4.
- NSYM, 64: symbols per frame, >= 2.
- FRAME_W, NSYM*6: output frame width in bits (64-QAM worst case).

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous active-high reset.
- in_mode, in, 2: 00 QPSK, 01 16-QAM, 10 64-QAM, 11 reserved (decoded as QPSK).
- in_valid, in, 1: symbol valid.
- in_ready, out, 1: demapper can accept a symbol.
- in_re, in, WIDTH: I sample.
- in_im, in, WIDTH: Q sample.
- out_valid, out, 1: frame valid.
- out_ready, in, 1: downstream accepts frame.
- out_bits, out, FRAME_W: packed frame.
- out_mode, out, 2: mode of the frame (00/01/10).
- out_nsym, out, clog2(NSYM+1): symbols in the frame.

Behaviour:
- Reset: out_valid=0, out_bits=0, out_mode=0, out_nsym=0, in_ready=0 while rst is high. in_ready=1 in the first cycle after rst falls.
- Reset mid-frame: partial assembly discarded, sym_cnt cleared, held output frame dropped.
- Symbol accepted on in_valid && in_ready.
- Mode is latched on the first symbol of a frame. in_mode changes mid-frame are ignored until the next frame.
- Scaling constant K by mode: QPSK 362 (sqrt2·256), 16-QAM 810 (sqrt10·256), 64-QAM 1659 (sqrt42·256). Constants are defined at FRAC=8 and shifted by (FRAC-8) for other FRAC.
- Scaled sample: s = (x*K) computed in 2*WIDTH bits, then arithmetic shift right by FRAC, then saturated to signed WIDTH.
- Per-axis thresholds, in units of 2^FRAC:
  - QPSK: {0}.
  - 16-QAM: {-2, 0, 2}.
  - 64-QAM: {-6, -4, -2, 0, 2, 4, 6}.
- Level L = count of thresholds t with s > t (strict; a value exactly on a threshold takes the lower level).
- Axis bits = L ^ (L>>1), i.e. b = 1, 2 or 3 bits per axis.
- Symbol field = {Q_gray, I_gray}, with I_gray in the LSBs; bps = 2b.
- Symbol k (0-based within frame) is written to out_bits[k*bps +: bps]. Bits at and above NSYM*bps are 0.
- Assembly FSM:
  - FILL: accept symbols, increment sym_cnt. On the NSYM-th symbol, go to XFER.
  - XFER: if the output register is empty, or is being consumed this cycle (out_valid && out_ready), copy assembly to output (out_valid=1, out_mode, out_nsym), clear assembly, go to FILL. Otherwise go to HOLD.
  - HOLD: in_ready=0; transfer as soon as the output slot frees, then go to FILL.
- Transfer occurs in the cycle after the last symbol is accepted, so latency from last symbol accepted to out_valid is 1 cycle when the output slot is free.
- in_ready=1 in FILL, 0 in XFER-blocked and HOLD.
- Simultaneous out_ready and transfer in the same cycle: the new frame replaces the old one with no bubble, and out_valid stays 1.
- out_bits, out_mode and out_nsym stay stable while out_valid && !out_ready.

Optional Feature:
- Macro: QAM_FLUSH_EN.
- When defined, adds input port in_flush (1 bit).
- in_flush is sampled only with an accepted symbol; that symbol becomes the last of the frame and the FSM enters XFER. out_nsym = symbols accepted, including that one; unused bits are 0.
- in_flush when no symbol is accepted is ignored.
- When undefined: no port, frames are always NSYM symbols, and out_nsym always equals NSYM.

Test Plan:
- Mode 01, NSYM=4, 4 symbols in_re=0x0100, in_im=0xFF00, out_ready=1 -> out_bits[15:0]=0x2222, upper bits 0, out_mode=01, out_nsym=4, out_valid 1 cycle after the 4th accept.
- Mode 00, NSYM=4, in_re=0x0010, in_im=0xFFF0 ×4 -> out_bits[7:0]=0x55; next frame with in_re=0, in_im=0 -> 0x00 (on-threshold takes the lower level).
- Mode 10, NSYM=4, in_re=0x0100, in_im=0x0000 ×4 -> each 6-bit field=0x14, out_bits[23:0]=0x514514; in_re=0x7FFF saturates to level 7 -> I field 3'b100.
- Backpressure, NSYM=4, out_ready=0, 12 symbols offered -> frame 1 held stable, frame 2 fills, in_ready drops after the 8th accept. out_ready=1 for one cycle -> frame 2 appears with no bubble, in_ready returns.
- Mode switched to 10 after symbol 2 of a 16-QAM frame -> frame reports out_mode=01 and is decoded entirely as 16-QAM. rst asserted after symbol 2 -> all outputs 0, next frame starts at symbol 0.
- QAM_FLUSH_EN defined, NSYM=4, mode 01, 3 symbols with in_flush on the 3rd -> out_nsym=3, out_bits[15:12]=0.

Source files
------------

// File: rtl/qam_demapper_multi.sv
// Hard-decision QPSK / 16-QAM / 64-QAM demapper that packs NSYM Gray-coded symbols per frame,
// double-buffered (assembly + output register). Define QAM_FLUSH_EN to add in_flush for short frames.
module qam_demapper_multi #(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter int NSYM    = 64,
  parameter int FRAME_W = NSYM * 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                in_mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_re,
  input  logic [WIDTH-1:0]          in_im,
`ifdef QAM_FLUSH_EN
  input  logic                      in_flush,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FRAME_W-1:0]        out_bits,
  output logic [1:0]                out_mode,
  output logic [$clog2(NSYM+1)-1:0] out_nsym
);

  localparam int CW = $clog2(NSYM + 1);
  localparam logic [1:0] MODE_QPSK = 2'b00;
  localparam logic [1:0] MODE_16   = 2'b01;
  localparam logic [1:0] MODE_64   = 2'b10;

  typedef enum logic [1:0] {FILL, XFER, HOLD} state_e;

  // Normalisation constants are tabulated at 8 fractional bits and rescaled to FRAC.
  function automatic int k_at_frac(input int k8);
    if (FRAC >= 8) return k8 << (FRAC - 8);
    else           return k8 >> (8 - FRAC);
  endfunction

  localparam logic signed [2*WIDTH-1:0] K_QPSK  = (2*WIDTH)'(k_at_frac(362));
  localparam logic signed [2*WIDTH-1:0] K_16    = (2*WIDTH)'(k_at_frac(810));
  localparam logic signed [2*WIDTH-1:0] K_64    = (2*WIDTH)'(k_at_frac(1659));
  localparam logic signed [2*WIDTH-1:0] SAT_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] SAT_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x,
                                                    input logic [1:0] mode);
    logic signed [2*WIDTH-1:0] k;
    logic signed [2*WIDTH-1:0] p;
    case (mode)
      MODE_16: k = K_16;
      MODE_64: k = K_64;
      default: k = K_QPSK;
    endcase
    p = (2*WIDTH)'(x) * k;
    p = p >>> FRAC;
    if (p > SAT_MAX)      p = SAT_MAX;
    else if (p < SAT_MIN) p = SAT_MIN;
    return p[WIDTH-1:0];
  endfunction

  // Thresholds sit at even multiples of 2^FRAC, symmetric about zero; 'half' picks how many.
  function automatic logic [2:0] gray_level(input logic signed [WIDTH-1:0] s,
                                            input logic [1:0] mode);
    int         half;
    logic [2:0] lvl;
    case (mode)
      MODE_16: half = 1;
      MODE_64: half = 3;
      default: half = 0;
    endcase
    lvl = '0;
    for (int t = -3; t <= 3; t++)
      if (t >= -half && t <= half && int'(s) > t * (2 << FRAC)) lvl = lvl + 3'd1;
    return lvl ^ (lvl >> 1);
  endfunction

  state_e             state_q, state_d;
  logic [CW-1:0]      sym_cnt_q, sym_cnt_d;
  logic [FRAME_W-1:0] asm_bits_q, asm_bits_d;
  logic [1:0]         frame_mode_q, frame_mode_d;
  logic               out_valid_q, out_valid_d;
  logic [FRAME_W-1:0] out_bits_q, out_bits_d;
  logic [1:0]         out_mode_q, out_mode_d;
  logic [CW-1:0]      out_nsym_q, out_nsym_d;

  logic [1:0] mode_in, cur_mode;
  logic [2:0] g_re, g_im;
  logic [5:0] field;
  int         bps;
  logic       accept, flush, last, slot_free, xfer;

`ifdef QAM_FLUSH_EN
  assign flush = in_flush;
`else
  assign flush = 1'b0;
`endif

  // Symbol decode; the first symbol of a frame takes the live mode, later ones the latched one.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    mode_in  = (in_mode == 2'b11) ? MODE_QPSK : in_mode;
    cur_mode = (sym_cnt_q == '0) ? mode_in : frame_mode_q;
    g_re     = gray_level(scale($signed(in_re), cur_mode), cur_mode);
    g_im     = gray_level(scale($signed(in_im), cur_mode), cur_mode);
    field    = '0;
    bps      = 2;
    case (cur_mode)
      MODE_16: begin field = {2'b00, g_im[1:0], g_re[1:0]}; bps = 4; end
      MODE_64: begin field = {g_im, g_re};                  bps = 6; end
      default: begin field = {4'b0000, g_im[0], g_re[0]};   bps = 2; end
    endcase
    accept    = in_valid && in_ready;
    last      = accept && (flush || sym_cnt_q == CW'(NSYM - 1));
    slot_free = !out_valid_q || out_ready;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (last) state_d = XFER;
      XFER:    state_d = slot_free ? FILL : HOLD;
      HOLD:    if (slot_free) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    xfer     = 1'b0;
    case (state_q)
      FILL:       in_ready = !rst;
      XFER, HOLD: xfer = slot_free;
      default:    ;
    endcase
  end

  // Accepts and transfers never coincide because in_ready is only raised in FILL.
  always_comb begin
    sym_cnt_d    = sym_cnt_q;
    asm_bits_d   = asm_bits_q;
    frame_mode_d = frame_mode_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_bits_d   = out_bits_q;
    out_mode_d   = out_mode_q;
    out_nsym_d   = out_nsym_q;
    if (accept) begin
      sym_cnt_d    = sym_cnt_q + CW'(1);
      asm_bits_d   = asm_bits_q | (FRAME_W'(field) << (int'(sym_cnt_q) * bps));
      frame_mode_d = cur_mode;
    end
    if (xfer) begin
      sym_cnt_d   = '0;
      asm_bits_d  = '0;
      out_valid_d = 1'b1;
      out_bits_d  = asm_bits_q;
      out_mode_d  = frame_mode_q;
      out_nsym_d  = sym_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sym_cnt_q    <= '0;
      asm_bits_q   <= '0;
      frame_mode_q <= MODE_QPSK;
      out_valid_q  <= 1'b0;
      out_bits_q   <= '0;
      out_mode_q   <= MODE_QPSK;
      out_nsym_q   <= '0;
    end else begin
      sym_cnt_q    <= sym_cnt_d;
      asm_bits_q   <= asm_bits_d;
      frame_mode_q <= frame_mode_d;
      out_valid_q  <= out_valid_d;
      out_bits_q   <= out_bits_d;
      out_mode_q   <= out_mode_d;
      out_nsym_q   <= out_nsym_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_bits  = out_bits_q;
  assign out_mode  = out_mode_q;
  assign out_nsym  = out_nsym_q;

endmodule

// File: tb/tb_qam_demapper_multi.sv
// Self-checking bench for qam_demapper_multi (NSYM=4): frame vector table plus a frame scoreboard;
// the in_flush sequence is compiled only when QAM_FLUSH_EN is defined.
module tb_qam_demapper_multi;

  localparam int WIDTH   = 16;
  localparam int FRAC    = 8;
  localparam int NSYM    = 4;
  localparam int FRAME_W = NSYM * 6;
  localparam int CW      = $clog2(NSYM + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         in_mode;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_re;
  logic [WIDTH-1:0]   in_im;
`ifdef QAM_FLUSH_EN
  logic               in_flush;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [FRAME_W-1:0] out_bits;
  logic [1:0]         out_mode;
  logic [CW-1:0]      out_nsym;

  qam_demapper_multi #(.WIDTH(WIDTH), .FRAC(FRAC), .NSYM(NSYM), .FRAME_W(FRAME_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
`ifdef QAM_FLUSH_EN
    .in_flush  (in_flush),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_mode  (out_mode),
    .out_nsym  (out_nsym)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FRAME_W-1:0] bits;
    logic [1:0]         mode;
    logic [CW-1:0]      nsym;
  } exp_t;

  typedef struct packed {
    logic [1:0]         mode;
    logic [3:0][15:0]   re;   // element k is symbol k
    logic [3:0][15:0]   im;
    logic [FRAME_W-1:0] exp_bits;
    logic [1:0]         exp_mode;
  } vec_t;

  vec_t vecs [8];
  exp_t sb_q [$];
  exp_t got;
  int   n_checks = 0;
  int   n_errors = 0;

  logic               held = 1'b0;
  logic [FRAME_W-1:0] held_bits;
  logic [1:0]         held_mode;
  logic [CW-1:0]      held_nsym;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_sym(input logic [1:0] mode, input logic [15:0] re, input logic [15:0] im);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_mode  = mode;
    in_re    = re;
    in_im    = im;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    #1;
    in_valid = 1'b0;
    check("sym_accepted", ok, 1'b1);
  endtask

  task automatic send_frame(input vec_t v);
    for (int k = 0; k < NSYM; k++) send_sym(v.mode, v.re[k], v.im[k]);
    sb_q.push_back('{bits: v.exp_bits, mode: v.exp_mode, nsym: CW'(NSYM)});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 0);
  endtask

  // Frame monitor: pops the scoreboard on each handshake and checks held frames stay stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_bits", out_bits, held_bits);
        check("hold_mode", out_mode, held_mode);
        check("hold_nsym", out_nsym, held_nsym);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_frame", out_valid, 1'b0);
        end else begin
          got = sb_q.pop_front();
          check("frame_bits", out_bits, got.bits);
          check("frame_mode", out_mode, got.mode);
          check("frame_nsym", out_nsym, got.nsym);
        end
      end
    end
    held      = out_valid && !out_ready && !rst;
    held_bits = out_bits;
    held_mode = out_mode;
    held_nsym = out_nsym;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{mode: 2'b01, re: {4{16'h0100}}, im: {4{16'hFF00}},
                exp_bits: 24'h002222, exp_mode: 2'b01};
    vecs[1] = '{mode: 2'b00, re: {4{16'h0010}}, im: {4{16'hFFF0}},
                exp_bits: 24'h000055, exp_mode: 2'b00};
    vecs[2] = '{mode: 2'b00, re: {4{16'h0000}}, im: {4{16'h0000}},
                exp_bits: 24'h000000, exp_mode: 2'b00};
    vecs[3] = '{mode: 2'b10, re: {4{16'h0100}}, im: {4{16'h0000}},
                exp_bits: 24'h514514, exp_mode: 2'b10};
    vecs[4] = '{mode: 2'b10, re: {4{16'h7FFF}}, im: {4{16'h8000}},
                exp_bits: 24'h104104, exp_mode: 2'b10};
    vecs[5] = '{mode: 2'b11, re: {16'hFFC0, 16'h0040, 16'hFFC0, 16'h0040},
                im: {16'hFFC0, 16'hFFC0, 16'h0040, 16'h0040},
                exp_bits: 24'h00001B, exp_mode: 2'b00};
    vecs[6] = '{mode: 2'b01, re: {16'hFF5D, 16'h0000, 16'h00A3, 16'h00A2},
                im: {16'hFFFF, 16'h00A3, 16'hFF5E, 16'h0000},
                exp_bits: 24'h004927, exp_mode: 2'b01};
    vecs[7] = '{mode: 2'b10, re: {16'h0040, 16'h0080, 16'h0040, 16'h0080},
                im: {16'h00C0, 16'hFF80, 16'h00C0, 16'hFF80},
                exp_bits: 24'hB9FB9F, exp_mode: 2'b10};

    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_re     = '0;
    in_im     = '0;
    out_ready = 1'b1;
`ifdef QAM_FLUSH_EN
    in_flush  = 1'b0;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_bits", out_bits, '0);
    check("rst_out_mode", out_mode, 2'b00);
    check("rst_out_nsym", out_nsym, '0);
    check("rst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // One-cycle latency from last accept to out_valid.
    send_frame(vecs[0]);
    @(negedge clk);
    check("latency_not_early", out_valid, 1'b0);
    @(negedge clk);
    check("latency_one_cycle", out_valid, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 1; i < 8; i++) send_frame(vecs[i]);
    drain();

    // Backpressure: frame A held, frame B fills then blocks, one-cycle out_ready swaps with no bubble.
    out_ready = 1'b0;
    send_frame(vecs[0]);
    send_frame(vecs[6]);
    @(negedge clk);
    check("bp_ready_drops", in_ready, 1'b0);
    repeat (3) @(negedge clk);
    check("bp_ready_stays_low", in_ready, 1'b0);
    check("bp_frame_a_bits", out_bits, 24'h002222);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp_no_bubble", out_valid, 1'b1);
    check("bp_frame_b_bits", out_bits, 24'h004927);
    check("bp_ready_returns", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send_frame(vecs[3]);
    @(negedge clk);
    check("bp_ready_low_again", in_ready, 1'b0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Mode change after symbol 2 is ignored until the next frame.
    for (int k = 0; k < NSYM; k++) send_sym((k < 2) ? 2'b01 : 2'b10, 16'h0100, 16'hFF00);
    sb_q.push_back('{bits: 24'h002222, mode: 2'b01, nsym: CW'(NSYM)});
    drain();

    // Reset after two symbols discards the partial frame and clears stale outputs.
    send_sym(2'b01, 16'h0100, 16'hFF00);
    send_sym(2'b01, 16'h0100, 16'hFF00);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_bits", out_bits, '0);
    check("midrst_out_mode", out_mode, 2'b00);
    check("midrst_out_nsym", out_nsym, '0);
    check("midrst_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    send_frame(vecs[3]);
    drain();

`ifdef QAM_FLUSH_EN
    // Flush on the third symbol closes a 3-symbol frame; flush without a symbol is ignored.
    send_sym(2'b01, 16'h0100, 16'hFF00);
    in_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_flush = 1'b0;
    send_sym(2'b01, 16'h0100, 16'hFF00);
    in_flush = 1'b1;
    send_sym(2'b01, 16'h0100, 16'hFF00);
    in_flush = 1'b0;
    sb_q.push_back('{bits: 24'h000222, mode: 2'b01, nsym: CW'(3)});
    drain();
    send_frame(vecs[0]);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
